// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: bus-width macros, counter limits and mask helpers.
// Optional feature macro used by this block: REG_SCOREBOARD_PERF_EN.
`ifndef REG_SCOREBOARD_DEFINES
`define REG_SCOREBOARD_DEFINES
`define REG_ADDR_BUS 4:0
`define WRITE_REG_REQ_ENABLE 1'b1
`define SB_CNT_BUS 2:0
`endif

package reg_scoreboard_pkg;
    localparam int REG_NUM    = 32;
    localparam int SB_CNT_W   = 3;
    localparam int SB_CNT_MAX = 7;

    typedef logic [REG_NUM-1:0] reg_mask_t;

    // One-hot register select; callers mask out x0 themselves.
    function automatic reg_mask_t reg_onehot(input logic [`REG_ADDR_BUS] addr);
        reg_mask_t mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/completion/status bundle between decode and the register scoreboard.
interface reg_scoreboard_if;
    logic                 issue_valid_i;
    logic                 issue_long_i;
    logic                 issue_csr_i;
    logic [`REG_ADDR_BUS] issue_rd_i;
    logic [`REG_ADDR_BUS] issue_rs1_i;
    logic [`REG_ADDR_BUS] issue_rs2_i;
    logic                 issue_rs1_use_i;
    logic                 issue_rs2_use_i;
    logic                 flush_i;
    logic                 done_req_i;
    logic [`REG_ADDR_BUS] done_rd_i;
    logic                 csr_done_i;
    logic                 stall_o;
    logic                 busy_o;
    logic                 err_o;

    modport master (
        output issue_valid_i, issue_long_i, issue_csr_i, issue_rd_i,
               issue_rs1_i, issue_rs2_i, issue_rs1_use_i, issue_rs2_use_i,
               flush_i, done_req_i, done_rd_i, csr_done_i,
        input  stall_o, busy_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_long_i, issue_csr_i, issue_rd_i,
               issue_rs1_i, issue_rs2_i, issue_rs1_use_i, issue_rs2_use_i,
               flush_i, done_req_i, done_rd_i, csr_done_i,
        output stall_o, busy_o, err_o
    );
endinterface

// File: rtl/reg_scoreboard_sb_hazard_cmp.sv
// Single-operand hazard check: register pending and not being written back this cycle.
module sb_hazard_cmp
    import reg_scoreboard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                 src_use,
    input  logic [`REG_ADDR_BUS] src_addr,
    input  reg_mask_t            pend,
    input  logic                 done_req,
    input  logic [`REG_ADDR_BUS] done_rd,
    output logic                 hazard
);
    logic bypass_hit;

    // The completing value is already on the forwarding path when bypass is enabled.
    assign bypass_hit = WB_BYPASS && done_req && (done_rd == src_addr);
    assign hazard     = src_use && (src_addr != '0) && pend[src_addr] && !bypass_hit;
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: pending bits for long-latency destinations and CSR writes, plus decode stall.
// Define REG_SCOREBOARD_PERF_EN to add a saturating stall-cycle counter on stall_cnt_o.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit WB_BYPASS       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_scoreboard_if.slave   sb
`ifdef REG_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);
    localparam logic [`SB_CNT_BUS] CNT_MAX = SB_CNT_W'(MAX_OUTSTANDING);

    reg_mask_t            pend_reg, pend_next;
    logic                 csr_pend_reg, csr_pend_next;
    logic [`SB_CNT_BUS]   cnt_reg, cnt_next;
    logic                 err_reg, err_next;
    logic                 busy_reg, busy_next;

    logic done_req;
    logic raw1_hz, raw2_hz, waw_hz, csr_hz, full_hz;
    logic hazard, stall, accept, set_long;
    logic done_pending, done_ok, done_err;
    reg_mask_t set_mask, clr_mask;

    assign done_req = (sb.done_req_i == `WRITE_REG_REQ_ENABLE);

    sb_hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs1 (
        .src_use (sb.issue_rs1_use_i),
        .src_addr(sb.issue_rs1_i),
        .pend    (pend_reg),
        .done_req(done_req),
        .done_rd (sb.done_rd_i),
        .hazard  (raw1_hz)
    );

    sb_hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rs2 (
        .src_use (sb.issue_rs2_use_i),
        .src_addr(sb.issue_rs2_i),
        .pend    (pend_reg),
        .done_req(done_req),
        .done_rd (sb.done_rd_i),
        .hazard  (raw2_hz)
    );

    sb_hazard_cmp #(.WB_BYPASS(WB_BYPASS)) u_cmp_rd (
        .src_use (sb.issue_long_i),
        .src_addr(sb.issue_rd_i),
        .pend    (pend_reg),
        .done_req(done_req),
        .done_rd (sb.done_rd_i),
        .hazard  (waw_hz)
    );

    assign csr_hz  = sb.issue_csr_i && csr_pend_reg;
    // Any completion frees a slot this cycle, even if it later turns out to be spurious.
    assign full_hz = sb.issue_long_i && (cnt_reg == CNT_MAX) && !done_req;
    assign hazard  = sb.issue_valid_i && (raw1_hz || raw2_hz || waw_hz || csr_hz || full_hz);
    assign stall   = hazard && !sb.flush_i;
    assign accept  = sb.issue_valid_i && !stall && !sb.flush_i;

    assign set_long     = accept && sb.issue_long_i;
    assign set_mask     = (set_long && (sb.issue_rd_i != '0)) ? reg_onehot(sb.issue_rd_i) : '0;
    assign done_pending = pend_reg[sb.done_rd_i];
    assign done_ok      = done_req && ((sb.done_rd_i == '0) || done_pending);
    assign done_err     = done_req && (sb.done_rd_i != '0) && !done_pending;
    assign clr_mask     = done_ok ? reg_onehot(sb.done_rd_i) : '0;

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign pend_next[gi] = 1'b0;
        end else begin : g_bit
            assign pend_next[gi] = set_mask[gi] || (pend_reg[gi] && !clr_mask[gi]);
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (set_long && !done_ok) begin
            if (cnt_reg != CNT_MAX)
                cnt_next = cnt_reg + 3'd1;
        end else if (!set_long && done_ok) begin
            if (cnt_reg != '0)
                cnt_next = cnt_reg - 3'd1;
        end
    end

    assign csr_pend_next = (accept && sb.issue_csr_i) || (csr_pend_reg && !sb.csr_done_i);
    assign err_next      = err_reg || done_err;
    // An outstanding op to x0 has no pending bit but still keeps the block busy.
    assign busy_next     = (|pend_next) || csr_pend_next || (cnt_next != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg     <= '0;
            csr_pend_reg <= 1'b0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            csr_pend_reg <= csr_pend_next;
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
        end
    end

    assign sb.stall_o = stall;
    assign sb.busy_o  = busy_reg;
    assign sb.err_o   = err_reg;

`ifdef REG_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic against an array model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int MAXO = 2;
    localparam bit BYP  = 1'b1;

    typedef struct packed {
        bit       valid;
        bit       lng;
        bit       csr;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
        bit       flush;
        bit       done;
        bit [4:0] drd;
        bit       cdone;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_scoreboard_if sb_if();

`ifdef REG_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    reg_scoreboard #(.MAX_OUTSTANDING(MAXO), .WB_BYPASS(BYP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb_if)
`ifdef REG_SCOREBOARD_PERF_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference state: what is in flight, as plain arrays and integers.
    bit pend_m [32];
    bit csr_m;
    int cnt_m;
    bit err_m;
    int stalls_m;

    logic obs_stall, obs_busy, obs_err;
    bit   exp_stall, exp_busy, exp_err;

    function automatic stim_t mk(bit valid, bit lng, bit csr, bit [4:0] rd,
                                 bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                                 bit flush, bit done, bit [4:0] drd, bit cdone);
        stim_t s;
        s.valid = valid; s.lng = lng;   s.csr = csr;   s.rd = rd;
        s.rs1 = rs1;     s.u1 = u1;     s.rs2 = rs2;   s.u2 = u2;
        s.flush = flush; s.done = done; s.drd = drd;   s.cdone = cdone;
        return s;
    endfunction

    function automatic stim_t st_long(bit [4:0] rd);
        return mk(1, 1, 0, rd, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t st_read(bit [4:0] rs1);
        return mk(1, 0, 0, 0, rs1, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t st_done(bit [4:0] drd);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, drd, 0);
    endfunction

    function automatic stim_t st_idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_reset();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        csr_m = 0; cnt_m = 0; err_m = 0; stalls_m = 0;
    endfunction

    function automatic bit covered(stim_t s, bit [4:0] r);
        return BYP && s.done && (s.drd == r);
    endfunction

    function automatic bit model_stall(stim_t s);
        bit hz = 0;
        if (!s.valid || s.flush) return 1'b0;
        if (s.u1 && s.rs1 != 0 && pend_m[s.rs1] && !covered(s, s.rs1)) hz = 1;
        if (s.u2 && s.rs2 != 0 && pend_m[s.rs2] && !covered(s, s.rs2)) hz = 1;
        if (s.lng && s.rd != 0 && pend_m[s.rd] && !covered(s, s.rd)) hz = 1;
        if (s.csr && csr_m) hz = 1;
        if (s.lng && cnt_m == MAXO && !s.done) hz = 1;
        return hz;
    endfunction

    function automatic void model_update(stim_t s, bit st);
        bit acc = s.valid && !st && !s.flush;
        if (s.done) begin
            if (s.drd != 0 && !pend_m[s.drd]) err_m = 1;
            else begin
                pend_m[s.drd] = 1'b0;
                cnt_m = cnt_m - 1;
            end
        end
        if (acc && s.lng) begin
            if (s.rd != 0) pend_m[s.rd] = 1'b1;
            cnt_m = cnt_m + 1;
        end
        if (cnt_m < 0) cnt_m = 0;
        if (cnt_m > MAXO) cnt_m = MAXO;
        if (s.cdone) csr_m = 0;
        if (acc && s.csr) csr_m = 1;
        if (st) stalls_m++;
    endfunction

    function automatic bit model_busy();
        bit any = 0;
        foreach (pend_m[i]) any |= pend_m[i];
        return any || csr_m || (cnt_m > 0);
    endfunction

    function automatic int pend_count();
        int n = 0;
        foreach (pend_m[i]) n += pend_m[i];
        return n;
    endfunction

    task automatic drive(stim_t s);
        sb_if.issue_valid_i   = s.valid;
        sb_if.issue_long_i    = s.lng;
        sb_if.issue_csr_i     = s.csr;
        sb_if.issue_rd_i      = s.rd;
        sb_if.issue_rs1_i     = s.rs1;
        sb_if.issue_rs1_use_i = s.u1;
        sb_if.issue_rs2_i     = s.rs2;
        sb_if.issue_rs2_use_i = s.u2;
        sb_if.flush_i         = s.flush;
        sb_if.done_req_i      = s.done;
        sb_if.done_rd_i       = s.drd;
        sb_if.csr_done_i      = s.cdone;
    endtask

    // Drives one cycle, samples stall mid-cycle and the registered outputs after the edge.
    task automatic step(stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        obs_stall = sb_if.stall_o;
        exp_stall = model_stall(s);
        @(posedge clk);
        model_update(s, exp_stall);
        #1;
        obs_busy = sb_if.busy_o;
        obs_err  = sb_if.err_o;
        exp_busy = model_busy();
        exp_err  = err_m;
        $display("step t=%0t v=%b L=%b c=%b rd=%0d rs1=%0d/%b rs2=%0d/%b fl=%b dn=%b/%0d cd=%b | stall=%b busy=%b err=%b",
                 $time, s.valid, s.lng, s.csr, s.rd, s.rs1, s.u1, s.rs2, s.u2,
                 s.flush, s.done, s.drd, s.cdone, obs_stall, obs_busy, obs_err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(st_idle());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (sb_if.stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", sb_if.stall_o); end
        total++; if (sb_if.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sb_if.busy_o); end
        total++; if (sb_if.err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", sb_if.err_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step(st_long(5));
        step(st_done(9));
        total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL reset_pre_err: got %b want 1", obs_err); end
        @(negedge clk);
        drive(st_read(5));
        #1;
        total++; if (sb_if.stall_o !== 1'b1) begin bad++; $display("FAIL reset_pre_stall: got %b want 1", sb_if.stall_o); end
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (sb_if.stall_o !== 1'b0) begin bad++; $display("FAIL reset_async_stall: got %b want 0", sb_if.stall_o); end
        total++; if (sb_if.busy_o !== 1'b0) begin bad++; $display("FAIL reset_async_busy: got %b want 0", sb_if.busy_o); end
        total++; if (sb_if.err_o !== 1'b0) begin bad++; $display("FAIL reset_async_err: got %b want 0", sb_if.err_o); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(st_read(5));
        total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL reset_x5_read: got %b want 0", obs_stall); end
    endtask

    task automatic test_load_use();
        stim_t q[$];
        q.push_back(st_long(5));
        q.push_back(st_read(5));
        q.push_back(st_read(5));
        q.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, 5, 0));
        q.push_back(st_read(5));
        q.push_back(st_idle());
        foreach (q[i]) begin
            step(q[i]);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL loaduse_stall step %0d: got %b want %b", i, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL loaduse_busy step %0d: got %b want %b", i, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL loaduse_err step %0d: got %b want %b", i, obs_err, exp_err); end
        end
    endtask

    task automatic test_x0_unused();
        stim_t q[$];
        q.push_back(st_long(0));
        q.push_back(st_long(5));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0));
        q.push_back(st_long(6));
        q.push_back(mk(1, 1, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(st_done(5));
        q.push_back(st_done(6));
        q.push_back(st_idle());
        foreach (q[i]) begin
            step(q[i]);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL x0_stall step %0d: got %b want %b", i, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL x0_busy step %0d: got %b want %b", i, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL x0_err step %0d: got %b want %b", i, obs_err, exp_err); end
        end
    endtask

    task automatic test_full_simul();
        stim_t q[$];
        q.push_back(st_long(3));
        q.push_back(st_long(7));
        q.push_back(st_long(8));
        q.push_back(mk(1, 1, 0, 8, 0, 0, 0, 0, 0, 1, 3, 0));
        q.push_back(mk(1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 7, 0));
        q.push_back(st_read(7));
        q.push_back(st_done(7));
        q.push_back(st_done(8));
        q.push_back(st_done(7));
        q.push_back(st_idle());
        foreach (q[i]) begin
            step(q[i]);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL full_stall step %0d: got %b want %b", i, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL full_busy step %0d: got %b want %b", i, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL full_err step %0d: got %b want %b", i, obs_err, exp_err); end
        end
    endtask

    task automatic test_flush();
        stim_t q[$];
        q.push_back(st_long(4));
        q.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0));
        q.push_back(st_read(9));
        q.push_back(st_read(4));
        q.push_back(st_done(4));
        q.push_back(st_idle());
        foreach (q[i]) begin
            step(q[i]);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL flush_stall step %0d: got %b want %b", i, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL flush_busy step %0d: got %b want %b", i, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL flush_err step %0d: got %b want %b", i, obs_err, exp_err); end
        end
    endtask

    task automatic test_err_csr();
        stim_t q[$];
        q.push_back(st_long(2));
        q.push_back(st_done(9));
        q.push_back(st_long(3));
        q.push_back(st_long(10));
        q.push_back(st_done(2));
        q.push_back(st_done(3));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        q.push_back(st_idle());
        foreach (q[i]) begin
            step(q[i]);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL errcsr_stall step %0d: got %b want %b", i, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL errcsr_busy step %0d: got %b want %b", i, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL errcsr_err step %0d: got %b want %b", i, obs_err, exp_err); end
        end
        total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL errcsr_sticky: got %b want 1", obs_err); end
    endtask

    task automatic test_random();
        stim_t s;
        bit [4:0] r;
        for (int n = 0; n < 400; n++) begin
            s = st_idle();
            s.valid = ($urandom_range(0, 3) != 0);
            s.lng   = $urandom_range(0, 1);
            s.csr   = ($urandom_range(0, 4) == 0);
            s.rd    = 5'($urandom_range(0, 7));
            s.rs1   = 5'($urandom_range(0, 7));
            s.u1    = $urandom_range(0, 1);
            s.rs2   = 5'($urandom_range(0, 7));
            s.u2    = $urandom_range(0, 1);
            s.flush = ($urandom_range(0, 7) == 0);
            r = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0 &&
                ((r != 0 && pend_m[r]) || (r == 0 && cnt_m > pend_count()))) begin
                s.done = 1'b1;
                s.drd  = r;
            end
            s.cdone = csr_m && ($urandom_range(0, 2) == 0);
            step(s);
            total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rand_stall iter %0d: got %b want %b", n, obs_stall, exp_stall); end
            total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL rand_busy iter %0d: got %b want %b", n, obs_busy, exp_busy); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rand_err iter %0d: got %b want %b", n, obs_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_unused();
        test_full_simul();
        test_flush();
        test_err_csr();
        test_random();
`ifdef REG_SCOREBOARD_PERF_EN
        total++;
        if (stall_cnt !== 32'(stalls_m)) begin
            bad++;
            $display("FAIL perf_stall_cnt: got %0d want %0d", stall_cnt, stalls_m);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks destination registers of in-flight long-latency instructions (loads, multi-cycle mul/div) between issue and writeback, and raises the decode-stage stall that the forwarding network cannot resolve. It sits beside the operand forwarding unit: forwarding serves results that already exist in MEM/WB, and this block holds issue until a pending result exists. One pending bit per architectural register, one bit for CSR writes, and an outstanding-operation counter.

## Interface
Parameters:
- MAX_OUTSTANDING, 2, maximum simultaneously pending long operations (1..7)
- WB_BYPASS, 1, 1 = completing register is forwarded, so no stall in its completion cycle

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode presents an instruction this cycle
- issue_long_i  in  1  instruction is long-latency and writes rd
- issue_csr_i  in  1  instruction writes a CSR
- issue_rd_i  in  `reg_addr_bus  destination register
- issue_rs1_i / issue_rs2_i  in  `reg_addr_bus  source registers
- issue_rs1_use_i / issue_rs2_use_i  in  1  source is actually read
- flush_i  in  1  pipeline flush; the issuing instruction is killed
- done_req_i  in  1  long op writes back, equal to `write_reg_req_enable
- done_rd_i  in  `reg_addr_bus  register completed
- csr_done_i  in  1  pending CSR write retired
- stall_o  out  1  hold decode/fetch this cycle
- busy_o  out  1  any register or CSR pending
- err_o  out  1  sticky: completion for a non-pending register

## Operation
- State: pend[31:1] (pend[0] constantly 0), csr_pend, cnt (outstanding ops), err.
- Hazard (combinational), asserted while issue_valid_i=1:
  - RAW: rsN_use and pend[rsN] and rsN≠0, unless WB_BYPASS=1 and done_req_i and done_rd_i==rsN
  - WAW: issue_long_i and rd≠0 and pend[rd], with the same bypass exception
  - CSR: issue_csr_i and csr_pend
  - Full: issue_long_i and cnt==MAX_OUTSTANDING and no completion this cycle
- stall_o = hazard and not flush_i. Flush overrides stall.
- Accept = issue_valid_i and not stall_o and not flush_i.
- Set: on accept with issue_long_i and rd≠0, pend[rd]←1 and cnt+1. On accept with issue_long_i and rd=0, cnt+1 only; the op completes with done_rd_i=0.
- Clear: done_req_i clears pend[done_rd_i] and decrements cnt. If pend was 0 and done_rd_i≠0, err←1 and cnt is unchanged.
- Simultaneous set and clear of the same register in one cycle: set wins, pend stays 1, cnt unchanged.
- csr_pend is set on accept with issue_csr_i and cleared by csr_done_i. If both occur in the same cycle, set wins.
- flush_i does not clear pending state, because already-issued long ops always complete.
- cnt saturates: it never exceeds MAX_OUTSTANDING and never goes below 0.

## Timing
- Reset (async, rst_n=0): pend=0, csr_pend=0, cnt=0, err=0, stall_o=0, busy_o=0, err_o=0.
- stall_o is combinational in the same cycle as issue inputs. All state updates occur on the next rising clk edge.
- Issue-to-stall latency: a long op accepted in cycle N causes a dependent instruction to stall from cycle N+1.
- Completion: with WB_BYPASS=1 the dependent instruction issues in the done cycle. With WB_BYPASS=0 it issues one cycle later.
- busy_o and err_o are registered outputs.

## Configuration
- REG_SCOREBOARD_PERF_EN defined: adds a 32-bit saturating stall-cycle counter, incremented every cycle stall_o=1, reset to 0, exposed as output stall_cnt_o[31:0].
- REG_SCOREBOARD_PERF_EN undefined: no counter and no port. Behaviour is otherwise identical.

## Structure
- Shared package/define.v holds: `reg_addr_bus, `write_reg_req_enable, and a new `sb_cnt_bus width define.
- One sub-module, sb_hazard_cmp: compares one source register against pend and the completion port, and is instantiated for rs1, rs2 and rd.
- The state registers stay in the top module.

## Test plan
- Reset: hold rst_n=0 mid-operation with pend[5]=1 → all outputs 0 immediately; after release, a read of x5 does not stall.
- Load-use RAW: issue long rd=5, then next cycle rs1=5 used → stall_o=1 until done_req_i with rd=5. The done cycle shows stall_o=0 with WB_BYPASS=1, and 1 with WB_BYPASS=0.
- x0 and unused source: long rd=0 gives cnt=1 and no pend. A source rs2=5 with rs2_use=0 while pend[5]=1 gives stall_o=0.
- Full and simultaneous events: MAX_OUTSTANDING=2 with two long ops pending, then a third long issue gives stall_o=1. A completion in the same cycle gives stall_o=0 and cnt stays 2. Set and clear of x7 in one cycle leaves pend[7]=1.
- Flush: a hazardous issue with flush_i=1 gives stall_o=0, no state change, and existing pend retained.
- Error and CSR: done for non-pending x9 sets err_o=1 (sticky) with cnt unchanged. A CSR write pending plus a second CSR issue gives a stall until csr_done_i.
